// File: rtl/conv_last_to_first_with_ready.sv
// Converts a last-delimited valid/ready stream into a first-delimited one,
// tagging each beat with its saturating index; output register plus skid entry.
module conv_last_to_first_with_ready #(
   parameter int width     = 8,
   parameter int idx_width = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 up_valid,
   output logic                 up_ready,
   input  logic                 up_last,
   input  logic [width-1:0]     up_data,
   output logic                 down_valid,
   input  logic                 down_ready,
   output logic                 down_first,
   output logic [width-1:0]     down_data,
   output logic [idx_width-1:0] down_index,
   output logic                 down_open
);

   typedef struct packed {
      logic [width-1:0]     data;
      logic                 first;
      logic [idx_width-1:0] idx;
      logic                 last;
   } entry_t;

   localparam logic [idx_width-1:0] IdxMax = '1;

   entry_t                 out_q, out_d, skid_q, skid_d, new_beat;
   logic                   out_vld_q, out_vld_d;
   logic                   skid_vld_q, skid_vld_d;
   logic                   sop_q, sop_d;
   logic [idx_width-1:0]   idx_q, idx_d;
   logic                   open_q, open_d;
   logic                   up_ready_q, up_ready_d;
   logic                   up_xfer, dn_xfer;

   assign up_xfer = up_valid & up_ready_q;
   assign dn_xfer = out_vld_q & down_ready;

   always_comb begin
      new_beat.data  = up_data;
      new_beat.first = sop_q;
      new_beat.idx   = idx_q;
      new_beat.last  = up_last;
   end

   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      sop_d      = sop_q;
      idx_d      = idx_q;
      open_d     = open_q;

      if (dn_xfer) begin
         // last wins over first so a one-beat packet leaves open at 0
         if (out_q.last)       open_d = 1'b0;
         else if (out_q.first) open_d = 1'b1;

         if (skid_vld_q) begin
            out_d      = skid_q;
            skid_vld_d = 1'b0;
         end else if (up_xfer) begin
            out_d = new_beat;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (up_xfer) begin
         // up_ready implies skid is empty, so a stalled out sends the beat to skid
         if (!out_vld_q) begin
            out_d     = new_beat;
            out_vld_d = 1'b1;
         end else begin
            skid_d     = new_beat;
            skid_vld_d = 1'b1;
         end
      end

      if (up_xfer) begin
         sop_d = up_last;
         if (up_last)              idx_d = '0;
         else if (idx_q != IdxMax) idx_d = idx_q + 1'b1;
      end

      up_ready_d = !skid_vld_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
         sop_q      <= 1'b1;
         idx_q      <= '0;
         open_q     <= 1'b0;
         up_ready_q <= 1'b1;
      end else begin
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
         sop_q      <= sop_d;
         idx_q      <= idx_d;
         open_q     <= open_d;
         up_ready_q <= up_ready_d;
      end
   end

   assign up_ready   = up_ready_q;
   assign down_valid = out_vld_q;
   assign down_first = out_q.first;
   assign down_data  = out_q.data;
   assign down_index = out_q.idx;
   assign down_open  = open_q;

endmodule

// File: tb/tb_conv_last_to_first_with_ready.sv
// Bench for conv_last_to_first_with_ready: directed table, corner sequences and
// random traffic against a packet-level FIFO model; idx_width 4 and 2 side by side.
module tb_conv_last_to_first_with_ready;

   logic       clock = 1'b0;
   logic       reset;
   logic       up_valid, up_last, down_ready;
   logic [7:0] up_data;
   logic       up_ready, down_valid, down_first, down_open;
   logic [7:0] down_data;
   logic [3:0] down_index;
   logic       up_ready2, down_valid2, down_first2, down_open2;
   logic [7:0] down_data2;
   logic [1:0] down_index2;

   always #5 clock = ~clock;

   conv_last_to_first_with_ready #(.width(8), .idx_width(4)) dut (
      .clock(clock), .reset(reset),
      .up_valid(up_valid), .up_ready(up_ready), .up_last(up_last), .up_data(up_data),
      .down_valid(down_valid), .down_ready(down_ready), .down_first(down_first),
      .down_data(down_data), .down_index(down_index), .down_open(down_open));

   conv_last_to_first_with_ready #(.width(8), .idx_width(2)) dut2 (
      .clock(clock), .reset(reset),
      .up_valid(up_valid), .up_ready(up_ready2), .up_last(up_last), .up_data(up_data),
      .down_valid(down_valid2), .down_ready(down_ready), .down_first(down_first2),
      .down_data(down_data2), .down_index(down_index2), .down_open(down_open2));

   // model: beats held inside the block, oldest first; index kept unbounded
   typedef struct {
      logic [7:0] data;
      logic       first;
      int         idx;
      logic       last;
   } mbeat_t;

   mbeat_t     mq[$];
   logic       m_sop  = 1'b1;
   int         m_idx  = 0;
   logic       m_open = 1'b0;
   logic [7:0] got[$];

   int n_cmp = 0;
   int n_err = 0;

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("up_ready", int'(up_ready), (mq.size() < 2) ? 1 : 0);
      chk("up_ready2", int'(up_ready2), (mq.size() < 2) ? 1 : 0);
      chk("down_valid", int'(down_valid), (mq.size() > 0) ? 1 : 0);
      chk("down_valid2", int'(down_valid2), (mq.size() > 0) ? 1 : 0);
      chk("down_open", int'(down_open), int'(m_open));
      chk("down_open2", int'(down_open2), int'(m_open));
      if (mq.size() > 0) begin
         chk("down_data", int'(down_data), int'(mq[0].data));
         chk("down_first", int'(down_first), int'(mq[0].first));
         chk("down_index", int'(down_index), sat(mq[0].idx, 15));
         chk("down_index2", int'(down_index2), sat(mq[0].idx, 3));
      end
   endtask

   task automatic step(input logic uv, input logic ul, input logic [7:0] ud,
                       input logic dr, input logic rst, output logic acc);
      logic   dx;
      mbeat_t b;
      up_valid   = uv;
      up_last    = ul;
      up_data    = ud;
      down_ready = dr;
      reset      = rst;
      acc = !rst && uv && (mq.size() < 2);
      dx  = !rst && dr && (mq.size() > 0);
      if (dx) got.push_back(down_data);
      @(posedge clock);
      #1;
      if (rst) begin
         mq.delete();
         m_sop  = 1'b1;
         m_idx  = 0;
         m_open = 1'b0;
      end else begin
         if (dx) begin
            b = mq.pop_front();
            if (b.last)       m_open = 1'b0;
            else if (b.first) m_open = 1'b1;
         end
         if (acc) begin
            mq.push_back('{data: ud, first: m_sop, idx: m_idx, last: ul});
            m_sop = ul;
            m_idx = ul ? 0 : m_idx + 1;
         end
      end
      check_model();
   endtask

   typedef struct {
      logic       uv, ul;
      logic [7:0] ud;
      logic       dr;
      logic       e_dv, e_first;
      logic [7:0] e_data;
      int         e_idx;
      logic       e_open, e_urdy;
   } vec_t;

   initial begin
      vec_t       vt[8];
      logic       acc;
      int         nxt;
      int         pat[6];
      int         sat_exp[6];
      bit         done;

      up_valid = 0; up_last = 0; up_data = 0; down_ready = 0; reset = 1;
      step(0, 0, 8'h00, 0, 1, acc);
      step(0, 0, 8'h00, 0, 1, acc);
      chk("rst_down_valid", int'(down_valid), 0);
      chk("rst_down_first", int'(down_first), 0);
      chk("rst_down_data", int'(down_data), 0);
      chk("rst_down_index", int'(down_index), 0);
      chk("rst_down_open", int'(down_open), 0);
      chk("rst_up_ready", int'(up_ready), 1);

      // 4-beat packet then three single-beat packets, downstream always ready
      vt[0] = '{1, 0, 8'hA0, 1, 1, 1, 8'hA0, 0, 0, 1};
      vt[1] = '{1, 0, 8'hA1, 1, 1, 0, 8'hA1, 1, 1, 1};
      vt[2] = '{1, 0, 8'hA2, 1, 1, 0, 8'hA2, 2, 1, 1};
      vt[3] = '{1, 1, 8'hA3, 1, 1, 0, 8'hA3, 3, 1, 1};
      vt[4] = '{1, 1, 8'hB0, 1, 1, 1, 8'hB0, 0, 0, 1};
      vt[5] = '{1, 1, 8'hB1, 1, 1, 1, 8'hB1, 0, 0, 1};
      vt[6] = '{1, 1, 8'hB2, 1, 1, 1, 8'hB2, 0, 0, 1};
      vt[7] = '{0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 1};
      for (int i = 0; i < 8; i++) begin
         step(vt[i].uv, vt[i].ul, vt[i].ud, vt[i].dr, 0, acc);
         chk("tbl_valid", int'(down_valid), int'(vt[i].e_dv));
         chk("tbl_open", int'(down_open), int'(vt[i].e_open));
         chk("tbl_up_ready", int'(up_ready), int'(vt[i].e_urdy));
         if (vt[i].e_dv) begin
            chk("tbl_first", int'(down_first), int'(vt[i].e_first));
            chk("tbl_data", int'(down_data), int'(vt[i].e_data));
            chk("tbl_index", int'(down_index), vt[i].e_idx);
         end
      end

      // backpressure: 8-beat packet, down_ready cycling 1,0,0,1,0,1
      pat = '{1, 0, 0, 1, 0, 1};
      got.delete();
      nxt  = 0;
      done = 0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (nxt >= 8 && mq.size() == 0) begin
            done = 1;
            break;
         end
         step(nxt < 8, nxt == 7, 8'h30 + 8'(nxt), pat[cyc % 6] != 0, 0, acc);
         if (acc) nxt++;
      end
      chk("bp_completed", int'(done), 1);
      chk("bp_count", got.size(), 8);
      for (int i = 0; i < got.size() && i < 8; i++)
         chk("bp_order", int'(got[i]), 8'h30 + i);

      // index saturation: 6-beat packet, then a fresh packet
      sat_exp = '{0, 1, 2, 3, 3, 3};
      for (int i = 0; i < 6; i++) begin
         step(1, i == 5, 8'h50 + 8'(i), 1, 0, acc);
         chk("sat_index2", int'(down_index2), sat_exp[i]);
         chk("sat_index", int'(down_index), i);
      end
      step(1, 0, 8'h60, 1, 0, acc);
      chk("sat_next_first", int'(down_first2), 1);
      chk("sat_next_index", int'(down_index2), 0);
      step(1, 1, 8'h61, 1, 0, acc);

      // gap of three idle cycles with X payload inside a packet
      step(1, 0, 8'hC0, 1, 0, acc);
      step(1, 0, 8'hC1, 1, 0, acc);
      for (int i = 0; i < 3; i++) step(0, 1'bx, 8'hxx, 1, 0, acc);
      chk("gap_idle_valid", int'(down_valid), 0);
      step(1, 0, 8'hC2, 1, 0, acc);
      chk("gap_first", int'(down_first), 0);
      chk("gap_index", int'(down_index), 2);
      step(1, 1, 8'hC3, 1, 0, acc);
      step(0, 0, 8'h00, 1, 0, acc);

      // reset in the middle of a packet, with a beat still held
      step(1, 0, 8'hE0, 1, 0, acc);
      step(1, 0, 8'hE1, 0, 0, acc);
      step(0, 0, 8'h00, 0, 1, acc);
      chk("mrst_valid", int'(down_valid), 0);
      chk("mrst_up_ready", int'(up_ready), 1);
      chk("mrst_open", int'(down_open), 0);
      step(1, 0, 8'hE2, 1, 0, acc);
      chk("mrst_first", int'(down_first), 1);
      chk("mrst_index", int'(down_index), 0);
      chk("mrst_data", int'(down_data), 8'hE2);

      // random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 8'($urandom),
              $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0, acc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/conv_last_to_first_with_ready.md
# conv_last_to_first_with_ready

Stream-framing converter: takes a valid/ready stream whose packets are delimited by a `last` flag on the final beat, and emits the same stream with packets delimited by a `first` flag on the opening beat. It sits on the transmit side of framing converters, upstream of consumers that need to know a packet is starting before it ends. It also annotates each beat with its position inside the packet. One registered stage plus a skid entry gives full throughput under backpressure.

## Interface
- `width`, 8: data width in bits.
- `idx_width`, 4: width of the beat-index output; the index saturates at all-ones.
- `clock`  input  1: rising-edge clock.
- `reset`  input  1: synchronous, active-high.
- `up_valid`  input  1: upstream beat present.
- `up_ready`  output  1: block can accept a beat; driven directly from a register.
- `up_last`  input  1: beat is the final beat of its packet.
- `up_data`  input  width: beat payload.
- `down_valid`  output  1: output beat present.
- `down_ready`  input  1: downstream accepts the beat.
- `down_first`  output  1: beat is the first beat of its packet.
- `down_data`  output  width: beat payload, unmodified.
- `down_index`  output  idx_width: 0-based beat position in the packet, saturating.
- `down_open`  output  1: a packet has started at the output and its last beat has not yet been transferred.

## Operation
- **Transfers.** An upstream transfer is `up_valid & up_ready`. A downstream transfer is `down_valid & down_ready`. Nothing changes on beats that are not transferred.
- **Start-of-packet tracking.** Register `sop` is 1 after reset. At each upstream transfer, `sop` takes the value of `up_last`.
  - A beat gets `first = 1` when `sop = 1` at the time it is accepted.
  - A single-beat packet (`up_last = 1` with `sop = 1`) gets `first = 1`. The next beat also gets `first = 1`.
- **Beat index.** Register `idx` is 0 after reset.
  - On an upstream transfer the beat captures the current `idx`.
  - `idx` then becomes 0 if `up_last = 1`, otherwise `min(idx + 1, 2^idx_width - 1)`.
- **Storage.** Two entries: the output register (`out`) and the skid register (`skid`). Each holds data, first and index.
  - On an upstream transfer the beat goes to `out` if `out` is empty or is being drained this cycle with `skid` empty. Otherwise it goes to `skid`.
  - When `out` drains and `skid` is full, `skid` moves to `out`.
  - A new accepted beat can never overtake a beat in `skid`.
- **up_ready.** Next-state value is `!skid_full_next`. This register is 1 after reset.
- **down_open.** Set on a downstream transfer with `down_first = 1`. Cleared on a downstream transfer whose beat carried `up_last = 1`, so each entry also stores `last`.
  - For a single-beat packet, the set and the clear happen in the same cycle and the result is 0.
  - `down_open` is internal status only; `down_last` is not an output.
- **Reset.** A reset asserted mid-packet discards both entries and returns `sop` to 1. The next accepted beat is flagged `first`.
- Reset values: `down_valid` 0, `down_first` 0, `down_data` 0, `down_index` 0, `down_open` 0, `up_ready` 1. Any handshake coinciding with `reset = 1` is ignored.

## Timing
- **Latency.** One cycle: a beat accepted at edge N is on `down_*` after edge N, when `out` was empty or draining.
- **Throughput.** With `down_ready` held at 1, one beat per cycle is sustained indefinitely and `up_ready` stays at 1.
- **Backpressure.**
  - If `down_ready` drops while beats stream, one more beat lands in `skid`.
  - `up_ready` is 0 from the following cycle.
  - No beat is lost or duplicated.
- **Release.** After `down_ready` returns to 1:
  - `out` drains on the first edge and `skid` moves to `out`.
  - `up_ready` is 1 from the cycle after that.
- **Output stability.** While `down_valid = 1` and `down_ready = 0`, all `down_*` outputs stay stable.
- **Idle upstream.** `up_valid = 0` with `out` draining makes `down_valid` 0 after the edge.
- **Ignored inputs.** `up_last` and `up_data` are don't-care when `up_valid = 0`. X on them must not reach `sop` or `idx`.

## Test plan
- **Reset/single packet.** Reset, then packet D0..D3 with `last` on D3 and `down_ready = 1` → outputs 1 cycle later. `first` = 1,0,0,0; `index` = 0,1,2,3; `down_open` = 1 after D0 transfers and 0 after D3.
- **Back-to-back singles.** Three one-beat packets (`last = 1` on each) → `first = 1` and `index = 0` on all three; `down_open` stays 0.
- **Backpressure.** Stream 8 beats while `down_ready` toggles 1,0,0,1,0,1 repeating → output order and data identical to input, `up_ready` never 1 while `skid` is full, no drop or duplicate. Checked by a scoreboard.
- **Index saturation.** With `idx_width = 2`, a 6-beat packet → `index` = 0,1,2,3,3,3. The following packet starts at `index` 0 with `first = 1`.
- **Mid-packet reset.** Accept 2 beats of a 4-beat packet, assert `reset` for 1 cycle → `down_valid = 0` and `up_ready = 1` after reset. The next beat has `first = 1` and `index = 0`.
- **Gaps.** `up_valid` idle for 3 cycles mid-packet with X on `up_data`/`up_last` → flags resume correctly, `first = 0` on the resumed beat.
